// File: rtl/pe_feeder.sv
// pe_feeder: buffers one ifm/weight pair and presents it to a border PE for one unary window.
// Optional macro UNARY_EARLY_TERM_EN: window length comes from cyc_lim + 1 instead of 2^(IWIDTH-1).

module pe_feeder #(
  parameter int IWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IWIDTH-1:0] in_ifm,
  input  logic signed [IWIDTH-1:0] in_wght,
  input  logic                     in_last,
`ifdef UNARY_EARLY_TERM_EN
  input  logic        [IWIDTH-2:0] cyc_lim,
`endif
  output logic signed [IWIDTH-1:0] ifm,
  output logic                     wght_sign,
  output logic        [IWIDTH-2:0] wght_abs,
  output logic                     en_i,
  output logic                     clr_i,
  output logic                     en_w,
  output logic                     clr_w,
  output logic                     en_o,
  output logic                     clr_o,
  output logic                     mac_done,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                   state;
  logic                     pend_valid;
  logic signed [IWIDTH-1:0] pend_ifm;
  logic signed [IWIDTH-1:0] pend_wght;
  logic                     pend_last;
  logic                     cur_last;
  logic                     first;
  logic        [IWIDTH-2:0] cnt;
  logic        [IWIDTH-2:0] cnt_inc;
  logic        [IWIDTH-2:0] lim_now;
  logic        [IWIDTH-1:0] neg_wght;
  logic        [IWIDTH-2:0] abs_wght;
  logic                     accept;
  logic                     final_cyc;
  logic                     pop;
  logic                     pend_valid_nxt;

`ifdef UNARY_EARLY_TERM_EN
  logic [IWIDTH-2:0] win_lim;

  // In LOAD the fresh cyc_lim decides the window; afterwards the latched copy does.
  assign lim_now = (state == LOAD) ? cyc_lim : win_lim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_lim <= '0;
    end else if (state == LOAD) begin
      win_lim <= cyc_lim;
    end
  end
`else
  assign lim_now = '1;
`endif

  assign accept         = in_valid && in_ready;
  assign final_cyc      = (state == RUN) && (cnt == lim_now);
  assign pop            = pend_valid && ((state == IDLE) || final_cyc);
  assign pend_valid_nxt = accept || (pend_valid && !pop);
  assign cnt_inc        = cnt + (IWIDTH-1)'(1);

  // Magnitude of the weight; the most negative code has no positive twin and saturates.
  assign neg_wght = -pend_wght;
  assign abs_wght = !pend_wght[IWIDTH-1] ? pend_wght[IWIDTH-2:0] :
                    neg_wght[IWIDTH-1]   ? '1 : neg_wght[IWIDTH-2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_ifm   <= '0;
      pend_wght  <= '0;
      pend_last  <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      if (accept) begin
        pend_valid <= 1'b1;
        pend_ifm   <= in_ifm;
        pend_wght  <= in_wght;
        pend_last  <= in_last;
      end else if (pop) begin
        pend_valid <= 1'b0;
      end
      in_ready <= !pend_valid_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      first     <= 1'b1;
      cur_last  <= 1'b0;
      ifm       <= '0;
      wght_sign <= 1'b0;
      wght_abs  <= '0;
      en_i      <= 1'b0;
      clr_i     <= 1'b0;
      en_w      <= 1'b0;
      clr_w     <= 1'b0;
      en_o      <= 1'b0;
      clr_o     <= 1'b0;
      mac_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      en_i     <= 1'b0;
      en_w     <= 1'b0;
      clr_i    <= 1'b0;
      clr_w    <= 1'b0;
      clr_o    <= 1'b0;
      mac_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_valid) begin
            state     <= LOAD;
            busy      <= 1'b1;
            ifm       <= pend_ifm;
            wght_sign <= pend_wght[IWIDTH-1];
            wght_abs  <= abs_wght;
            cur_last  <= pend_last;
            en_i      <= 1'b1;
            en_w      <= 1'b1;
            clr_o     <= first;
            first     <= 1'b0;
          end
        end
        LOAD: begin
          state    <= RUN;
          cnt      <= '0;
          en_o     <= 1'b1;
          mac_done <= cur_last && (lim_now == '0);
        end
        RUN: begin
          if (cnt == lim_now) begin
            cnt  <= '0;
            en_o <= 1'b0;
            // A waiting pair starts its LOAD straight away, so no idle cycle is spent.
            if (pend_valid) begin
              state     <= LOAD;
              ifm       <= pend_ifm;
              wght_sign <= pend_wght[IWIDTH-1];
              wght_abs  <= abs_wght;
              cur_last  <= pend_last;
              en_i      <= 1'b1;
              en_w      <= 1'b1;
              clr_o     <= cur_last;
              first     <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              clr_i <= 1'b1;
              clr_w <= 1'b1;
              first <= cur_last;
            end
          end else begin
            cnt      <= cnt_inc;
            mac_done <= cur_last && (cnt_inc == lim_now);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: scoreboard bench for pe_feeder; the monitor pops expected pairs on every LOAD.
// Builds with or without UNARY_EARLY_TERM_EN.

module tb_pe_feeder;

  localparam int W = 128;

  typedef struct {
    logic signed [7:0] ifm;
    logic              sign;
    logic        [6:0] abs;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_ifm;
  logic signed [7:0] in_wght;
  logic              in_last;
  logic signed [7:0] ifm;
  logic              wght_sign;
  logic        [6:0] wght_abs;
  logic              en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done, busy;
`ifdef UNARY_EARLY_TERM_EN
  logic        [6:0] cyc_lim;
`endif

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t exp_q[$];
  int   load_cyc[$];
  int   load_clr[$];
  int   win_len[$];
  int   done_pos[$];
  int   done_win[$];
  int   clri_cyc[$];
  int   run_len   = 0;
  logic prev_en_o = 1'b0;
  logic signed [7:0] cur_ifm = '0;
  logic stall_seen = 1'b0;

  pe_feeder #(.IWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ifm(in_ifm), .in_wght(in_wght), .in_last(in_last),
`ifdef UNARY_EARLY_TERM_EN
    .cyc_lim(cyc_lim),
`endif
    .ifm(ifm), .wght_sign(wght_sign), .wght_abs(wght_abs),
    .en_i(en_i), .clr_i(clr_i), .en_w(en_w), .clr_w(clr_w),
    .en_o(en_o), .clr_o(clr_o), .mac_done(mac_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] ref_abs(input int w);
    if (w == -128) return 7'd127;
    if (w < 0) return 7'(-w);
    return 7'(w);
  endfunction

  // Monitor: scoreboard pops on en_i and records window statistics for the scenario tasks.
  always @(negedge clk) begin
    if (prev_en_o && !en_o) begin
      win_len.push_back(run_len);
      run_len = 0;
    end
    if (en_o) begin
      run_len++;
      checks++;
      if (ifm !== cur_ifm) begin
        errors++;
        $display("[TB] FAIL ifm_stable got=%0d want=%0d", ifm, cur_ifm);
      end
    end
    if (mac_done) begin
      done_pos.push_back(run_len);
      done_win.push_back(load_cyc.size());
    end
    if (en_i || en_w) begin
      checks++;
      if (en_w !== en_i) begin
        errors++;
        $display("[TB] FAIL en_w_pair got=%0b want=%0b", en_w, en_i);
      end
    end
    if (en_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_underflow got=load want=none");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (ifm !== e.ifm || wght_sign !== e.sign || wght_abs !== e.abs) begin
          errors++;
          $display("[TB] FAIL sb_pair got=%0d/%0b/%0d want=%0d/%0b/%0d",
                   ifm, wght_sign, wght_abs, e.ifm, e.sign, e.abs);
        end
      end
      load_cyc.push_back(cyc);
      load_clr.push_back(int'(clr_o));
      cur_ifm = ifm;
    end
    if (clr_i || clr_w) begin
      clri_cyc.push_back(cyc);
      checks++;
      if (clr_w !== clr_i) begin
        errors++;
        $display("[TB] FAIL clr_w_pair got=%0b want=%0b", clr_w, clr_i);
      end
    end
    prev_en_o = en_o;
  end

  task automatic clear_stats();
    load_cyc.delete(); load_clr.delete(); win_len.delete();
    done_pos.delete(); done_win.delete(); clri_cyc.delete();
    run_len = 0;
    stall_seen = 1'b0;
  endtask

  // Presents a pair (called at a negedge) and holds it until accepted; pushes the expectation.
  task automatic send(input logic signed [7:0] i, input logic signed [7:0] w,
                      input logic l, output int acc);
    int   t = 0;
    exp_t e;
    in_ifm = i; in_wght = w; in_last = l; in_valid = 1'b1;
    while (!in_ready && t < 1000) begin
      stall_seen = 1'b1;
      @(negedge clk);
      t++;
    end
    acc = cyc;
    if (t >= 1000) begin
      checks++; errors++;
      $display("[TB] FAIL send_timeout got=%0d want=<1000", t);
    end else begin
      e.ifm = i; e.sign = w[7]; e.abs = ref_abs(int'(w));
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || !in_ready || exp_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("[TB] FAIL idle_timeout got=%0d want=<3000", t);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, en_i, en_w, en_o, clr_i, clr_w, clr_o, mac_done} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got=%b want=00000000",
               {busy, en_i, en_w, en_o, clr_i, clr_w, clr_o, mac_done});
    end
    checks++;
    if ({ifm, wght_sign, wght_abs} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_data got=%h want=0000", {ifm, wght_sign, wght_abs});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready got=%b want=1", in_ready);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int acc;
    clear_stats();
    send(8'sd5, -8'sd3, 1'b1, acc);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_ready_full got=%b want=0", in_ready);
    end
    wait_idle();
    checks++;
    if (load_cyc.size() !== 1 || load_cyc[0] - acc !== 2 || load_clr[0] !== 1) begin
      errors++;
      $display("[TB] FAIL single_load got=n%0d lat%0d clr%0d want=n1 lat2 clr1",
               load_cyc.size(), load_cyc.size() ? load_cyc[0] - acc : -1,
               load_clr.size() ? load_clr[0] : -1);
    end
    checks++;
    if (win_len.size() !== 1 || win_len[0] !== W) begin
      errors++;
      $display("[TB] FAIL single_window got=%0d want=%0d", win_len.size() ? win_len[0] : -1, W);
    end
    checks++;
    if (done_pos.size() !== 1 || done_pos[0] !== W) begin
      errors++;
      $display("[TB] FAIL single_done got=%0d want=%0d", done_pos.size() ? done_pos[0] : -1, W);
    end
    checks++;
    if (clri_cyc.size() !== 1 || load_cyc.size() !== 1 || clri_cyc[0] - load_cyc[0] !== W + 1) begin
      errors++;
      $display("[TB] FAIL single_clr_iw got=n%0d want=n1 at load+%0d", clri_cyc.size(), W + 1);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    clear_stats();
    send(8'sd1, 8'sd2, 1'b0, acc);
    send(8'sd3, -8'sd4, 1'b0, acc);
    send(-8'sd7, 8'sd9, 1'b1, acc);
    wait_idle();
    checks++;
    if (load_cyc.size() !== 3) begin
      errors++;
      $display("[TB] FAIL b2b_loads got=%0d want=3", load_cyc.size());
    end else begin
      checks++;
      if (load_cyc[1] - load_cyc[0] !== W + 1 || load_cyc[2] - load_cyc[1] !== W + 1) begin
        errors++;
        $display("[TB] FAIL b2b_spacing got=%0d,%0d want=%0d", load_cyc[1] - load_cyc[0],
                 load_cyc[2] - load_cyc[1], W + 1);
      end
      checks++;
      if (load_clr[0] !== 1 || load_clr[1] !== 0 || load_clr[2] !== 0) begin
        errors++;
        $display("[TB] FAIL b2b_clr_o got=%0d%0d%0d want=100", load_clr[0], load_clr[1], load_clr[2]);
      end
    end
    checks++;
    if (done_win.size() !== 1 || done_win[0] !== 3) begin
      errors++;
      $display("[TB] FAIL b2b_done got=n%0d win%0d want=n1 win3", done_win.size(),
               done_win.size() ? done_win[0] : -1);
    end
    checks++;
    if (clri_cyc.size() !== 1) begin
      errors++;
      $display("[TB] FAIL b2b_idle_gaps got=%0d want=1", clri_cyc.size());
    end
  endtask

  task automatic test_saturate();
    int acc;
    clear_stats();
    send(8'sd0, -8'sd128, 1'b1, acc);
    send(-8'sd1, 8'sd127, 1'b1, acc);
    wait_idle();
    checks++;
    if (load_clr.size() !== 2 || load_clr[0] !== 1 || load_clr[1] !== 1) begin
      errors++;
      $display("[TB] FAIL sat_clr_o got=n%0d want=n2 both 1", load_clr.size());
    end
    checks++;
    if (done_pos.size() !== 2) begin
      errors++;
      $display("[TB] FAIL sat_done got=%0d want=2", done_pos.size());
    end
  endtask

  task automatic test_stall();
    int acc;
    clear_stats();
    for (int k = 0; k < 4; k++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), k == 3, acc);
    end
    wait_idle();
    checks++;
    if (stall_seen !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_seen got=%b want=1", stall_seen);
    end
    checks++;
    if (load_cyc.size() !== 4 || exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL stall_count got=%0d left%0d want=4 left0", load_cyc.size(), exp_q.size());
    end
    checks++;
    if (done_win.size() !== 1 || done_win[0] !== 4) begin
      errors++;
      $display("[TB] FAIL stall_done got=n%0d want=n1 win4", done_win.size());
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    int t = 0;
    clear_stats();
    send(8'sd5, -8'sd3, 1'b1, acc);
    while (!en_i && t < 20) begin
      @(negedge clk);
      t++;
    end
    send(8'sd9, 8'sd9, 1'b0, acc);
    repeat (60) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, en_i, en_w, en_o, clr_i, clr_w, clr_o, mac_done, ifm, wght_sign, wght_abs} !== 24'h0
        || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset got=%b rdy=%b want=0 rdy=1",
               {busy, en_i, en_o, mac_done, ifm, wght_abs}, in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_stats();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_pend_flush got=%b want=0", busy);
    end
    send(8'sd2, 8'sd3, 1'b1, acc);
    wait_idle();
    checks++;
    if (load_clr.size() !== 1 || load_clr[0] !== 1 || load_cyc[0] - acc !== 2) begin
      errors++;
      $display("[TB] FAIL restart_clr_o got=n%0d want=n1 clr1 lat2", load_clr.size());
    end
  endtask

`ifdef UNARY_EARLY_TERM_EN
  task automatic test_early_term();
    int acc;
    int t = 0;
    clear_stats();
    cyc_lim = 7'd15;
    send(8'sd4, 8'sd5, 1'b1, acc);
    while (!en_i && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    cyc_lim = 7'd3;
    wait_idle();
    checks++;
    if (win_len.size() !== 1 || win_len[0] !== 16 || done_pos.size() !== 1 || done_pos[0] !== 16) begin
      errors++;
      $display("[TB] FAIL early_term got=%0d/%0d want=16/16",
               win_len.size() ? win_len[0] : -1, done_pos.size() ? done_pos[0] : -1);
    end
    cyc_lim = 7'd127;
  endtask
`endif

  initial begin
    in_valid = 1'b0; in_ifm = '0; in_wght = '0; in_last = 1'b0;
`ifdef UNARY_EARLY_TERM_EN
    cyc_lim = 7'd127;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_saturate();
    test_stall();
    test_reset_mid();
`ifdef UNARY_EARLY_TERM_EN
    test_early_term();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
